apu_dispatcher: RTL
===================

// Module: apu_dispatcher
// PURPOSE
// - Core-side initiator of the APU offload interface: takes vector instructions from the core pipeline and drives apu_req/op/operands.
// - Completes the request/grant handshake, tracks outstanding requests, and returns apu_result to the core writeback port.
// - Responses return in order; the accelerator-side decoder is the responder on the same interface.
// PARAMETERS
// - OP_W            6   width of apu_op / instr_op
// - DATA_W          32  operand and result width
// - MAX_OUTSTANDING 4   granted-but-unanswered requests allowed (power of 2, >=2)
// - TIMEOUT_CYCLES  256 response watchdog limit (used only with APU_TIMEOUT_EN)
// PORTS
// - clk            in   1         clock, rising edge
// - n_reset        in   1         asynchronous active-low reset
// - instr_valid    in   1         core offers an instruction
// - instr_ready    out  1         dispatcher accepts this cycle
// - instr_op       in   OP_W      operation code
// - instr_operands in   3*DATA_W  {op_c, op_b, op_a}
// - instr_rd       in   5         destination register tag
// - apu_req        out  1         request to accelerator
// - apu_gnt        in   1         accelerator grant
// - apu_op         out  OP_W      registered op, stable while apu_req=1
// - apu_operands   out  3*DATA_W  registered operands, stable while apu_req=1
// - apu_rvalid     in   1         result valid (1-cycle pulse per request)
// - apu_result     in   DATA_W    result data
// - wb_valid       out  1         1-cycle writeback pulse
// - wb_rd          out  5         tag of completed request
// - wb_data        out  DATA_W    result for writeback
// - wb_err         out  1         completion is a timeout, not a result
// - busy           out  1         request pending or count>0
// - protocol_err   out  1         sticky: rvalid with nothing outstanding
// BEHAVIOUR
// - Reset: state=IDLE, count=0, tag FIFO empty. apu_req, wb_valid, wb_err, protocol_err, busy=0; apu_op, apu_operands, wb_rd, wb_data=0.
// - Async reset mid-operation: apu_req drops immediately; pending and outstanding requests are discarded.
// - FSM IDLE: instr_ready = (count < MAX_OUTSTANDING). On instr_valid&&instr_ready:
//   latch op/operands/rd, go REQ. apu_req rises the next cycle.
// - FSM REQ: apu_req=1 and op/operands held constant until apu_gnt. instr_ready=0.
//   On apu_gnt in the same cycle: push rd into the tag FIFO, count+1, go IDLE. apu_req=0 next cycle.
//   apu_gnt outside REQ is ignored.
// - Throughput: at most 1 request per 2 cycles (accept->req). Minimum grant latency is 0 cycles after apu_req rises.
// - apu_rvalid with count>0: pop the FIFO. Next cycle: wb_valid=1, wb_rd=popped tag, wb_data=registered apu_result, wb_err=0. count-1.
// - apu_rvalid with count==0, including the same cycle as the first grant: ignored, protocol_err<=1 until reset.
// - Simultaneous gnt and rvalid: push and pop in the same cycle; count unchanged.
// - count saturates at MAX_OUTSTANDING. IDLE with count==MAX blocks acceptance; freed entry allows accept in the cycle after the pop.
// - FIFO pointers wrap modulo MAX_OUTSTANDING.
// - busy = (state==REQ) || (count!=0).
// - wb_valid and wb_err are registered outputs; wb_rd and wb_data hold their last value when wb_valid=0.
// CONFIGURATION
// - APU_TIMEOUT_EN defined:
//   - Watchdog counter runs while count>0 and clears on every pop.
//   - On reaching TIMEOUT_CYCLES: pop the oldest tag and emit wb_valid=1, wb_err=1, wb_data=0. count-1, counter cleared.
//   - An apu_rvalid in the same cycle as the timeout takes priority, giving a normal completion.
// - APU_TIMEOUT_EN undefined: no watchdog logic, wb_err tied 0, and the dispatcher waits for rvalid indefinitely.
// TESTING
// - Single op, rd=5, operands a=3 b=4, gnt 2 cycles after req, rvalid 3 cycles later with result=7 -> one wb_valid, wb_rd=5, wb_data=7, busy back to 0.
// - gnt held low 10 cycles -> apu_req stays 1 with apu_op/apu_operands unchanged and instr_ready=0 throughout.
// - MAX_OUTSTANDING=4: issue 4 ops with gnt=1 and no rvalid -> instr_ready=0 with 5th valid. One rvalid -> 5th accepted.
//   wb_rd order matches issue order (rd 1,2,3,4).
// - gnt for 3rd op in the same cycle as rvalid for 1st -> count stays 2, wb_rd=1, FIFO order intact across pointer wrap.
// - rvalid with count=0 -> no wb_valid, protocol_err=1 until n_reset. Async reset during REQ -> apu_req=0 before the next edge.
// - APU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no rvalid -> wb_valid with wb_err=1, wb_data=0 at cycle 16 after grant. Undefined: no wb pulse.

Source files
------------

// File: rtl/apu_dispatcher.sv
// APU offload initiator: issues one request at a time, keeps granted tags in an in-order
// FIFO and returns results to writeback. Optional response watchdog: APU_TIMEOUT_EN.
module apu_dispatcher #(
  parameter int OP_W            = 6,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_op,
  input  logic [3*DATA_W-1:0] instr_operands,
  input  logic [4:0]          instr_rd,
  output logic                apu_req,
  input  logic                apu_gnt,
  output logic [OP_W-1:0]     apu_op,
  output logic [3*DATA_W-1:0] apu_operands,
  input  logic                apu_rvalid,
  input  logic [DATA_W-1:0]   apu_result,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic                wb_err,
  output logic                busy,
  output logic                protocol_err,
  output logic                state_dbg
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // Handshakes: a core instruction transfers on a rising edge with instr_valid && instr_ready;
  // a request transfers with apu_req && apu_gnt; apu_rvalid is a one-cycle pulse, no backpressure.
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [3*DATA_W-1:0]   opnds_q, opnds_d;
  logic [4:0]            rd_q, rd_d;
  logic [4:0]            tag_q [MAX_OUTSTANDING];
  logic [4:0]            tag_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wb_valid_q, wb_valid_d, wb_err_q, wb_err_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  perr_q, perr_d;
  logic                  push, rv_pop, pop, timeout_fire;

  assign push   = (state_q == REQ) && apu_gnt;
  assign rv_pop = apu_rvalid && (count_q != '0);
  assign pop    = rv_pop || timeout_fire;

`ifdef APU_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // A real response in the same cycle always wins over the watchdog.
  always_comb begin
    timeout_fire = (count_q != '0) && !apu_rvalid && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    wd_d = (count_q == '0 || pop) ? '0 : wd_q + WD_W'(1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opnds_d    = opnds_q;
    rd_d       = rd_q;
    tag_d      = tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wb_valid_d = pop;
    wb_err_d   = timeout_fire;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    perr_d     = perr_q || (apu_rvalid && count_q == '0);
    case (state_q)
      IDLE: if (instr_valid && instr_ready) begin
        op_d    = instr_op;
        opnds_d = instr_operands;
        rd_d    = instr_rd;
        state_d = REQ;
      end
      REQ: if (apu_gnt) begin
        tag_d[wr_ptr_q] = rd_q;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      wb_rd_d   = tag_q[rd_ptr_q];
      wb_data_d = rv_pop ? apu_result : '0;
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop && count_q != MAX_CNT) count_d = count_q + CNT_W'(1);
    else if (!push && pop)                  count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      opnds_q    <= '0;
      rd_q       <= '0;
      tag_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      opnds_q    <= opnds_d;
      rd_q       <= rd_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_err_q   <= wb_err_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      perr_q     <= perr_d;
    end
  end

  assign instr_ready  = (state_q == IDLE) && (count_q < MAX_CNT);
  assign apu_req      = (state_q == REQ);
  assign apu_op       = op_q;
  assign apu_operands = opnds_q;
  assign wb_valid     = wb_valid_q;
  assign wb_err       = wb_err_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign busy         = (state_q == REQ) || (count_q != '0);
  assign protocol_err = perr_q;
  assign state_dbg    = state_q;
endmodule
